seg_sequence_checker: RTL and testbench

Receive-side monitor for the 7-segment display bus. Samples a 7-bit segment pattern, debounces it, decodes it back to a BCD digit, and checks that successive digits follow the 0→1→…→9→0 counting order. Sits at the far end of the segment bus, in front of the digit counter and encoder. Provides pulses and saturating counters for on-board self-test and for the verification bench.

---
 rtl/seg_sequence_checker.sv | 126 ++++++++++++
 tb/tb_seg_sequence_checker.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seg_sequence_checker.sv
// rtl/seg_sequence_checker.sv - debounces a 7-segment pattern, decodes it and checks 0..9 counting order.
// Optional build macro SEG_BLANK_EN: treat the all-off pattern as a silent blank instead of an invalid pattern.
module seg_sequence_checker #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        invalid_pattern,
  output logic        seq_error,
  output logic        locked,
  output logic [15:0] accept_count,
  output logic [15:0] error_count
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES - 1);

  typedef enum logic {ACQUIRE, LOCKED} state_t;

  state_t         r_state;
  logic [6:0]     r_seg_q;
  logic [6:0]     r_last_pat;
  logic           r_last_pat_vld;
  logic [CW-1:0]  r_stab_cnt;

  logic           w_match;
  logic           w_event;
  logic           w_dec_vld;
  logic [3:0]     w_dec_digit;
  logic [3:0]     w_inc_digit;
  logic           w_blank;

  always_comb begin
    w_dec_vld   = 1'b1;
    w_dec_digit = 4'd0;
    case (r_seg_q)
      7'b0111111: w_dec_digit = 4'd0;
      7'b0000110: w_dec_digit = 4'd1;
      7'b1011011: w_dec_digit = 4'd2;
      7'b1001111: w_dec_digit = 4'd3;
      7'b1100110: w_dec_digit = 4'd4;
      7'b1101101: w_dec_digit = 4'd5;
      7'b1111101: w_dec_digit = 4'd6;
      7'b0000111: w_dec_digit = 4'd7;
      7'b1111111: w_dec_digit = 4'd8;
      7'b1101111: w_dec_digit = 4'd9;
      default:    w_dec_vld   = 1'b0;
    endcase
  end

`ifdef SEG_BLANK_EN
  assign w_blank = (r_seg_q == 7'd0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_match     = (seg_in == r_seg_q);
  assign w_event     = w_match && (r_stab_cnt == FULL) &&
                       (!r_last_pat_vld || (r_seg_q != r_last_pat));
  assign w_inc_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  // Sampled through reset so a pattern held across reset counts from the first free edge.
  always_ff @(posedge clk) begin
    r_seg_q <= seg_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stab_cnt     <= '0;
      r_last_pat     <= 7'd0;
      r_last_pat_vld <= 1'b0;
    end else begin
      if (!w_match)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != FULL)
        r_stab_cnt <= r_stab_cnt + CW'(1);
      if (w_event) begin
        r_last_pat     <= r_seg_q;
        r_last_pat_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ACQUIRE;
      digit           <= 4'd0;
      digit_valid     <= 1'b0;
      invalid_pattern <= 1'b0;
      seq_error       <= 1'b0;
      locked          <= 1'b0;
      accept_count    <= 16'd0;
      error_count     <= 16'd0;
    end else begin
      digit_valid     <= 1'b0;
      invalid_pattern <= 1'b0;
      seq_error       <= 1'b0;
      if (w_event && !w_blank) begin
        if (!w_dec_vld) begin
          invalid_pattern <= 1'b1;
          r_state         <= ACQUIRE;
          locked          <= 1'b0;
          if (error_count != 16'hFFFF)
            error_count <= error_count + 16'd1;
        end else begin
          digit       <= w_dec_digit;
          digit_valid <= 1'b1;
          r_state     <= LOCKED;
          locked      <= 1'b1;
          if (accept_count != 16'hFFFF)
            accept_count <= accept_count + 16'd1;
          // Out-of-order digit: flag it, then resync on the new value.
          if ((r_state == LOCKED) && (w_dec_digit != w_inc_digit)) begin
            seq_error <= 1'b1;
            if (error_count != 16'hFFFF)
              error_count <= error_count + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_sequence_checker.sv
// tb/tb_seg_sequence_checker.sv - scoreboard bench for seg_sequence_checker (STABLE_CYCLES=4).
module tb_seg_sequence_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  digit;
  logic        digit_valid, invalid_pattern, seq_error, locked;
  logic [15:0] accept_count, error_count;

  seg_sequence_checker #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .digit(digit),
    .digit_valid(digit_valid), .invalid_pattern(invalid_pattern),
    .seq_error(seq_error), .locked(locked),
    .accept_count(accept_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit       dv, inv, sq;
    int       dg;
    bit       lk;
    int       acc, err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;
  logic [6:0] pat [10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      check("rst_digit", digit, 0);
      check("rst_pulses", {digit_valid, invalid_pattern, seq_error}, 0);
      check("rst_locked", locked, 0);
      check("rst_accept", accept_count, 0);
      check("rst_error", error_count, 0);
    end else if (digit_valid || invalid_pattern || seq_error) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event dv=%0d inv=%0d seq=%0d digit=%0d expected=none (cycle %0d)",
                 digit_valid, invalid_pattern, seq_error, digit, cyc);
      end else begin
        e = sb.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("digit_valid", digit_valid, e.dv);
        check("invalid_pattern", invalid_pattern, e.inv);
        check("seq_error", seq_error, e.sq);
        check("digit", digit, e.dg);
        check("locked", locked, e.lk);
        check("accept_count", accept_count, e.acc);
        check("error_count", error_count, e.err);
      end
    end
    if (done) begin
      check("pending_events", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic push(input int c, input bit dv, inv, sq, input int dg, input bit lk,
                      input int acc, err);
    exp_t e;
    e.cyc = c; e.dv = dv; e.inv = inv; e.sq = sq;
    e.dg = dg; e.lk = lk; e.acc = acc; e.err = err;
    sb.push_back(e);
  endtask

  // Called just after a negedge; a new pattern is sampled on the next edge and accepted 4 edges later.
  task automatic step(input logic [6:0] p, input int n, input bit ev, input bit dv, inv, sq,
                      input int dg, input bit lk, input int acc, err);
    seg_in = p;
    if (ev) push(cyc + 5, dv, inv, sq, dg, lk, acc, err);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
    pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h6F;
    rst = 1'b1;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      step(pat[i % 10], 8, 1, 1, 0, 0, i % 10, 1, i + 1, 0);

    step(pat[3], 8, 1, 1, 0, 1, 3, 1, 12, 1);
    step(7'h7F, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    step(pat[3], 8, 0, 0, 0, 0, 0, 0, 0, 0);

    step(7'h40, 10, 1, 0, 1, 0, 3, 0, 12, 2);
    step(pat[5], 8, 1, 1, 0, 0, 5, 1, 13, 2);

    step(pat[2], 8, 1, 1, 0, 1, 2, 1, 14, 3);
    step(pat[4], 8, 1, 1, 0, 1, 4, 1, 15, 4);
    step(pat[5], 8, 1, 1, 0, 0, 5, 1, 16, 4);

    step(pat[7], 8, 1, 1, 0, 1, 7, 1, 17, 5);
`ifdef SEG_BLANK_EN
    step(7'h00, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    step(pat[8], 8, 1, 1, 0, 0, 8, 1, 18, 5);
`else
    step(7'h00, 8, 1, 0, 1, 0, 7, 0, 17, 6);
    step(pat[8], 8, 1, 1, 0, 0, 8, 1, 18, 6);
`endif

    seg_in = pat[6];
    k = cyc;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push(k + 8, 1, 0, 0, 6, 1, 1, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
